// File: rtl/ipml_sync_fifo_wconv.sv
// ipml_sync_fifo_wconv: single-clock FIFO with asymmetric write/read widths.
//
// Data are stored as U-bit units, where U is the narrower of the two port
// widths. A write deposits WR_DATA_WIDTH/U units and a read removes
// RD_DATA_WIDTH/U units. This lets one storage array serve both the
// narrow-to-wide (packing) and the wide-to-narrow (unpacking) direction.
// Units are packed little-endian: the low unit of a wide word is first in time.
//
// Read modes:
//   FWFT = 0 : rd_data is registered. It loads the head word on a popping edge.
//   FWFT = 1 : rd_data shows the head word combinationally while not empty.
//
// Optional build macro IPML_FIFO_ERR_FLAG_EN:
//   Defined   : sticky overflow/underflow flags are built. They clear on rst.
//   Undefined : overflow and underflow are tied low and no registers exist.

module ipml_sync_fifo_wconv #(
    parameter int WR_DATA_WIDTH    = 64,
    parameter int RD_DATA_WIDTH    = 16,
    parameter int WR_DEPTH_WIDTH   = 4,
    parameter int RD_DEPTH_WIDTH   = 6,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 14,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      overflow,
    output logic                      underflow
);

    // Storage geometry. Everything below is expressed in U-bit units.
    localparam int UNIT_W       = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int WR_UNITS     = WR_DATA_WIDTH / UNIT_W;
    localparam int RD_UNITS     = RD_DATA_WIDTH / UNIT_W;
    localparam int WR_UNITS_LOG = $clog2(WR_UNITS);
    localparam int RD_UNITS_LOG = $clog2(RD_UNITS);
    localparam int PTR_W        = (WR_DEPTH_WIDTH > RD_DEPTH_WIDTH) ? WR_DEPTH_WIDTH : RD_DEPTH_WIDTH;
    localparam int CNT_W        = PTR_W + 1;
    localparam int DEPTH        = 1 << PTR_W;
    localparam int WL_W         = WR_DEPTH_WIDTH + 1;
    localparam int RL_W         = RD_DEPTH_WIDTH + 1;

    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] WR_STEP  = CNT_W'(WR_UNITS);
    localparam logic [CNT_W-1:0] RD_STEP  = CNT_W'(RD_UNITS);
    localparam logic [PTR_W-1:0] WR_ADV   = PTR_W'(WR_UNITS);
    localparam logic [PTR_W-1:0] RD_ADV   = PTR_W'(RD_UNITS);

    logic [UNIT_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]         wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]         rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     wrAccept;
    logic                     rdAccept;
    logic [RD_DATA_WIDTH-1:0] headWord;

    // Status flags and water levels are pure functions of the registered unit
    // count. A level is the number of whole words of that port's width. The
    // power-of-two ratio turns each division into a shift.
    always_comb begin
        wr_full        = (CAPACITY - count_q) < WR_STEP;
        rd_empty       = count_q < RD_STEP;
        wr_water_level = WL_W'(count_q >> WR_UNITS_LOG);
        rd_water_level = RL_W'(count_q >> RD_UNITS_LOG);
        almost_full    = int'(wr_water_level) >= ALMOST_FULL_NUM;
        almost_empty   = int'(rd_water_level) <= ALMOST_EMPTY_NUM;
    end

    // A request counts only when its side has room or data. A write and a read
    // on the same edge are independent. Each sees the state before the edge.
    always_comb begin
        wrAccept = wr_en && !wr_full;
        rdAccept = rd_en && !rd_empty;
    end

    // Next-state pointers and count. The pointers wrap naturally at the array
    // size. The count moves by the net number of units written and read.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + WR_ADV;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + RD_ADV;
        end
        count_d = count_q + (wrAccept ? WR_STEP : '0) - (rdAccept ? RD_STEP : '0);
    end

    // Pointer and count registers. Reset wins over any same-edge transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array. It is never cleared. An accepted write splits the word
    // into units, low unit first, at consecutive slots from the write pointer.
    always_ff @(posedge clk) begin
        if (!rst && wrAccept) begin
            for (int i = 0; i < WR_UNITS; i++) begin
                mem[wrPtr_q + PTR_W'(i)] <= wr_data[i*UNIT_W +: UNIT_W];
            end
        end
    end

    // Reassemble the word at the head of the queue. The unit at the read
    // pointer becomes the least significant slice.
    always_comb begin
        headWord = '0;
        for (int j = 0; j < RD_UNITS; j++) begin
            headWord[j*UNIT_W +: UNIT_W] = mem[rdPtr_q + PTR_W'(j)];
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // In fall-through mode the head word is shown directly. A pop only
            // advances the read pointer.
            assign rd_data = headWord;
        end else begin : g_std
            logic [RD_DATA_WIDTH-1:0] rdData_q;

            // In standard mode the output register captures the head word on a
            // popping edge. It holds its value at every other edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdData_q <= '0;
                end else if (rdAccept) begin
                    rdData_q <= headWord;
                end
            end

            assign rd_data = rdData_q;
        end
    endgenerate

`ifdef IPML_FIFO_ERR_FLAG_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags. A rejected request sets its flag. The flag stays set
    // until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && wr_full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ipml_sync_fifo_wconv.sv
// Testbench for ipml_sync_fifo_wconv.
// It builds two instances:
//   dutA : 64-bit write, 16-bit read (unpacking), standard read mode.
//   dutB : 16-bit write, 64-bit read (packing), FWFT mode.
// A queue-of-units reference model predicts levels, flags and read data.
// Each monitor pops its expected-word queue when its DUT presents a word.

module tb_ipml_sync_fifo_wconv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        wrEnA, rdEnA;
    logic [63:0] wrDataA;
    logic [15:0] rdDataA;
    logic        wrFullA, almostFullA, rdEmptyA, almostEmptyA, overflowA, underflowA;
    logic [4:0]  wrLevelA;
    logic [6:0]  rdLevelA;

    logic        wrEnB, rdEnB;
    logic [15:0] wrDataB;
    logic [63:0] rdDataB;
    logic        wrFullB, almostFullB, rdEmptyB, almostEmptyB, overflowB, underflowB;
    logic [6:0]  wrLevelB;
    logic [4:0]  rdLevelB;

`ifdef IPML_FIFO_ERR_FLAG_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] unitsA[$];
    logic [15:0] expA[$];
    logic [15:0] lastA;
    bit          ovfA, udfA;

    logic [15:0] unitsB[$];
    logic [63:0] expB[$];
    bit          ovfB, udfB;

    logic        firedA;

    ipml_sync_fifo_wconv #(
        .WR_DATA_WIDTH(64), .RD_DATA_WIDTH(16), .WR_DEPTH_WIDTH(4), .RD_DEPTH_WIDTH(6),
        .FWFT(0), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) dutA (
        .clk(clk), .rst(rst),
        .wr_en(wrEnA), .wr_data(wrDataA), .wr_full(wrFullA), .almost_full(almostFullA),
        .wr_water_level(wrLevelA),
        .rd_en(rdEnA), .rd_data(rdDataA), .rd_empty(rdEmptyA), .almost_empty(almostEmptyA),
        .rd_water_level(rdLevelA),
        .overflow(overflowA), .underflow(underflowA)
    );

    ipml_sync_fifo_wconv #(
        .WR_DATA_WIDTH(16), .RD_DATA_WIDTH(64), .WR_DEPTH_WIDTH(6), .RD_DEPTH_WIDTH(4),
        .FWFT(1), .ALMOST_FULL_NUM(60), .ALMOST_EMPTY_NUM(2)
    ) dutB (
        .clk(clk), .rst(rst),
        .wr_en(wrEnB), .wr_data(wrDataB), .wr_full(wrFullB), .almost_full(almostFullB),
        .wr_water_level(wrLevelB),
        .rd_en(rdEnB), .rd_data(rdDataB), .rd_empty(rdEmptyB), .almost_empty(almostEmptyB),
        .rd_water_level(rdLevelB),
        .overflow(overflowB), .underflow(underflowB)
    );

    // Single comparison point. It counts every check and reports each failure.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected flags and levels, derived from the stored unit count using the
    // flag definitions of the FIFO.
    task automatic checkLevels(input string tag, input int size, input int wu, input int ru,
                               input int cap, input int af, input int ae,
                               input bit expOvf, input bit expUdf,
                               input logic full, input logic afull, input logic [31:0] wl,
                               input logic empty, input logic aempty, input logic [31:0] rl,
                               input logic ovf, input logic udf);
        checkOutput({tag, " wr_full"},        full,   64'((cap - size) < wu));
        checkOutput({tag, " almost_full"},    afull,  64'((size / wu) >= af));
        checkOutput({tag, " wr_water_level"}, wl,     64'(size / wu));
        checkOutput({tag, " rd_empty"},       empty,  64'(size < ru));
        checkOutput({tag, " almost_empty"},   aempty, 64'((size / ru) <= ae));
        checkOutput({tag, " rd_water_level"}, rl,     64'(size / ru));
        checkOutput({tag, " overflow"},       ovf,    64'(expOvf & ERR_ON));
        checkOutput({tag, " underflow"},      udf,    64'(expUdf & ERR_ON));
    endtask

    task automatic checkA();
        checkLevels("A", unitsA.size(), 4, 1, 64, 14, 2, ovfA, udfA,
                    wrFullA, almostFullA, 32'(wrLevelA), rdEmptyA, almostEmptyA, 32'(rdLevelA),
                    overflowA, underflowA);
        checkOutput("A rd_data hold", 64'(rdDataA), 64'(lastA));
    endtask

    task automatic checkB();
        checkLevels("B", unitsB.size(), 1, 4, 64, 60, 2, ovfB, udfB,
                    wrFullB, almostFullB, 32'(wrLevelB), rdEmptyB, almostEmptyB, 32'(rdLevelB),
                    overflowB, underflowB);
    endtask

    // One cycle on dutA: drive, update the model, wait one edge, then check.
    task automatic applyStimulusA(input bit we, input logic [63:0] wd, input bit re);
        bit wa, ra;
        wrEnA   = we;
        wrDataA = wd;
        rdEnA   = re;
        wa = we && ((64 - unitsA.size()) >= 4);
        ra = re && (unitsA.size() >= 1);
        if (we && !wa) ovfA = 1'b1;
        if (re && !ra) udfA = 1'b1;
        if (ra) begin
            lastA = unitsA.pop_front();
            expA.push_back(lastA);
        end
        if (wa) begin
            for (int k = 0; k < 4; k++) unitsA.push_back(wd[k*16 +: 16]);
        end
        @(posedge clk);
        #1;
        wrEnA = 1'b0;
        rdEnA = 1'b0;
        checkA();
    endtask

    // One cycle on dutB. A read assembles four units, first unit in the low bits.
    task automatic applyStimulusB(input bit we, input logic [15:0] wd, input bit re);
        bit wa, ra;
        logic [63:0] w;
        wrEnB   = we;
        wrDataB = wd;
        rdEnB   = re;
        wa = we && (unitsB.size() < 64);
        ra = re && (unitsB.size() >= 4);
        if (we && !wa) ovfB = 1'b1;
        if (re && !ra) udfB = 1'b1;
        if (ra) begin
            for (int k = 0; k < 4; k++) w[k*16 +: 16] = unitsB.pop_front();
            expB.push_back(w);
        end
        if (wa) unitsB.push_back(wd);
        @(posedge clk);
        #1;
        wrEnB = 1'b0;
        rdEnB = 1'b0;
        checkB();
    endtask

    // Synchronous reset of both DUTs. It can carry a write on the reset edge;
    // that write must be dropped.
    task automatic doReset(input bit withWrite);
        rst     = 1'b1;
        wrEnA   = withWrite;
        wrDataA = {$urandom, $urandom};
        wrEnB   = withWrite;
        wrDataB = 16'($urandom);
        rdEnA   = 1'b0;
        rdEnB   = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wrEnA = 1'b0;
        wrEnB = 1'b0;
        unitsA.delete();
        unitsB.delete();
        expA.delete();
        expB.delete();
        lastA = '0;
        ovfA = 1'b0; udfA = 1'b0;
        ovfB = 1'b0; udfB = 1'b0;
        checkA();
        checkB();
    endtask

    // Monitor A: a pop handshake seen at the falling edge means the registered
    // word appears after the next rising edge.
    always @(negedge clk) begin
        firedA = rdEnA && !rdEmptyA && !rst;
        if (firedA) begin
            @(posedge clk);
            #2;
            if (expA.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL A read data: got %0h, expected no word", rdDataA);
            end else begin
                checkOutput("A read data", 64'(rdDataA), 64'(expA.pop_front()));
            end
        end
    end

    // Monitor B: in fall-through mode the popped word is on rd_data before the
    // popping edge.
    always @(negedge clk) begin
        if (rdEnB && !rdEmptyB && !rst) begin
            if (expB.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL B read data: got %0h, expected no word", rdDataB);
            end else begin
                checkOutput("B read data", rdDataB, expB.pop_front());
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] wb[4];

        rst = 1'b1;
        wrEnA = 1'b0; rdEnA = 1'b0; wrDataA = '0;
        wrEnB = 1'b0; rdEnB = 1'b0; wrDataB = '0;
        firedA = 1'b0;
        lastA = '0;
        ovfA = 1'b0; udfA = 1'b0; ovfB = 1'b0; udfB = 1'b0;

        $display("[TB] reset");
        doReset(1'b0);

        $display("[TB] A: unpack one wide word");
        applyStimulusA(1'b1, 64'h4444_3333_2222_1111, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulusA(1'b0, '0, 1'b1);
        applyStimulusA(1'b0, '0, 1'b0);

        $display("[TB] A: fill to capacity and overfill");
        for (int i = 0; i < 17; i++) applyStimulusA(1'b1, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 64; i++) applyStimulusA(1'b0, '0, 1'b1);

        $display("[TB] A: simultaneous write and read");
        applyStimulusA(1'b1, {$urandom, $urandom}, 1'b0);
        applyStimulusA(1'b1, {$urandom, $urandom}, 1'b0);
        applyStimulusA(1'b1, {$urandom, $urandom}, 1'b1);

        $display("[TB] A: reset mid-burst with write on reset edge");
        doReset(1'b0);
        for (int i = 0; i < 5; i++) applyStimulusA(1'b1, {$urandom, $urandom}, 1'b0);
        doReset(1'b1);
        applyStimulusA(1'b0, '0, 1'b1);
        applyStimulusA(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0);
        applyStimulusA(1'b0, '0, 1'b1);

        $display("[TB] A: randomized traffic");
        for (int i = 0; i < 200; i++)
            applyStimulusA($urandom_range(0, 99) < 60, {$urandom, $urandom}, $urandom_range(0, 99) < 50);
        for (int i = 0; i < 200; i++)
            applyStimulusA($urandom_range(0, 99) < 15, {$urandom, $urandom}, $urandom_range(0, 99) < 90);
        for (int i = 0; i < 70 && unitsA.size() > 0; i++) applyStimulusA(1'b0, '0, 1'b1);

        $display("[TB] B: pack narrow words, fall-through read");
        doReset(1'b0);
        for (int i = 0; i < 4; i++) wb[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) applyStimulusB(1'b1, wb[i], 1'b0);
        checkOutput("B fwft head", rdDataB, {wb[3], wb[2], wb[1], wb[0]});
        applyStimulusB(1'b0, '0, 1'b1);
        applyStimulusB(1'b0, '0, 1'b1);

        $display("[TB] B: randomized traffic");
        for (int i = 0; i < 150; i++)
            applyStimulusB($urandom_range(0, 99) < 90, 16'($urandom), $urandom_range(0, 99) < 10);
        for (int i = 0; i < 150; i++)
            applyStimulusB($urandom_range(0, 99) < 30, 16'($urandom), $urandom_range(0, 99) < 40);
        for (int i = 0; i < 20 && unitsB.size() >= 4; i++) applyStimulusB(1'b0, '0, 1'b1);

        @(posedge clk);
        #3;
        checkOutput("A scoreboard drained", 64'(expA.size()), 64'd0);
        checkOutput("B scoreboard drained", 64'(expB.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
